// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder: RISC-V load/store
// funct3 codes and the responder FSM state encoding.
package dmem_responder_pkg;

   localparam logic [2:0] LB  = 3'b000;
   localparam logic [2:0] LH  = 3'b001;
   localparam logic [2:0] LW  = 3'b010;
   localparam logic [2:0] LBU = 3'b100;
   localparam logic [2:0] LHU = 3'b101;
   localparam logic [2:0] SB  = 3'b000;
   localparam logic [2:0] SH  = 3'b001;
   localparam logic [2:0] SW  = 3'b010;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_RESP = 2'd2
   } state_e;

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational byte-lane logic for the data-memory responder.
// Ports:
//   funct3, write, addr_lo : access size/sign, direction, byte offset
//   old_word               : current contents of the addressed word
//   wdata                  : store data, LSB-aligned
//   load_data              : extracted and extended load result
//   store_word             : old_word with the addressed lanes replaced
//   fmt_err                : undefined funct3 or misaligned access
module dmem_lane_align
   import dmem_responder_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic        write,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] old_word,
   input  logic [31:0] wdata,
   output logic [31:0] load_data,
   output logic [31:0] store_word,
   output logic        fmt_err
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   assign byte_sel = old_word[{addr_lo, 3'b000} +: 8];
   assign half_sel = old_word[{addr_lo[1], 4'b0000} +: 16];

   always_comb begin
      load_data  = '0;
      store_word = old_word;
      fmt_err    = 1'b0;
      // LB/SB, LH/SH, LW/SW share codes; direction selects the behaviour
      case (funct3)
         LB: begin
            if (write) store_word[{addr_lo, 3'b000} +: 8] = wdata[7:0];
            else       load_data = {{24{byte_sel[7]}}, byte_sel};
         end
         LH: begin
            if (addr_lo[0])  fmt_err = 1'b1;
            else if (write)  store_word[{addr_lo[1], 4'b0000} +: 16] = wdata[15:0];
            else             load_data = {{16{half_sel[15]}}, half_sel};
         end
         LW: begin
            if (addr_lo != 2'b00) fmt_err = 1'b1;
            else if (write)       store_word = wdata;
            else                  load_data = old_word;
         end
         LBU: begin
            if (write) fmt_err = 1'b1;
            else       load_data = {24'h0, byte_sel};
         end
         LHU: begin
            if (write || addr_lo[0]) fmt_err = 1'b1;
            else                     load_data = {16'h0, half_sel};
         end
         default: fmt_err = 1'b1;
      endcase
   end

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder with fixed response latency.
// Ports:
//   clk, reset        : rising-edge clock, async active-low reset
//   req_*             : request handshake and fields (captured on accept)
//   rsp_*             : response handshake, load data and error flag
// The storage array 'memory' is deliberately not reset.
//
// state  | meaning
// IDLE   | ready for a request (req_ready=1)
// WAIT   | counting LATENCY-1 cycles after acceptance
// RESP   | response held until rsp_ready
module dmem_responder
   import dmem_responder_pkg::*;
#(
   parameter int DEPTH_WORDS = 32,
   parameter int LATENCY     = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_error
);

   localparam int         IDX_W     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam logic [3:0] WAIT_LAST = 4'(LATENCY - 2);

   logic [31:0] memory [DEPTH_WORDS];

   state_e      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        write_q, write_d;
   logic [2:0]  funct3_q, funct3_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] rdata_q, rdata_d;
   logic        error_q, error_d;

   logic        accept, commit, mem_we, in_range, fmt_err;
   logic        a_write;
   logic [2:0]  a_funct3;
   logic [31:0] a_addr, a_wdata, old_word, load_data, store_word;
   logic [IDX_W-1:0] idx;

   assign req_ready = (state_q == S_IDLE);
   assign rsp_valid = (state_q == S_RESP);
   assign rsp_rdata = rdata_q;
   assign rsp_error = error_q;
   assign accept    = req_valid & req_ready;

   // With LATENCY=1 the commit happens on the accepting edge, before the
   // capture registers hold the request, so use the live request fields.
   always_comb begin
      if (state_q == S_IDLE) begin
         a_write  = req_write;
         a_funct3 = req_funct3;
         a_addr   = req_addr;
         a_wdata  = req_wdata;
      end else begin
         a_write  = write_q;
         a_funct3 = funct3_q;
         a_addr   = addr_q;
         a_wdata  = wdata_q;
      end
   end

   assign in_range = ({2'b00, a_addr[31:2]} < 32'(DEPTH_WORDS));
   assign idx      = a_addr[IDX_W+1:2];
   assign old_word = in_range ? memory[idx] : '0;

   dmem_lane_align u_lane_align (
      .funct3     (a_funct3),
      .write      (a_write),
      .addr_lo    (a_addr[1:0]),
      .old_word   (old_word),
      .wdata      (a_wdata),
      .load_data  (load_data),
      .store_word (store_word),
      .fmt_err    (fmt_err)
   );

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      write_d  = write_q;
      funct3_d = funct3_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      rdata_d  = rdata_q;
      error_d  = error_q;
      commit   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               write_d  = req_write;
               funct3_d = req_funct3;
               addr_d   = req_addr;
               wdata_d  = req_wdata;
               cnt_d    = '0;
               if (LATENCY == 1) begin
                  state_d = S_RESP;
                  commit  = 1'b1;
               end else begin
                  state_d = S_WAIT;
               end
            end
         end
         S_WAIT: begin
            if (cnt_q == WAIT_LAST) begin
               state_d = S_RESP;
               commit  = 1'b1;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         S_RESP: begin
            if (rsp_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      if (commit) begin
         error_d = fmt_err | ~in_range;
         rdata_d = (error_d || a_write) ? 32'h0 : load_data;
      end
   end

   // Gating with reset keeps a clock edge during reset from committing a store.
   assign mem_we = commit & a_write & ~error_d & reset;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         write_q  <= 1'b0;
         funct3_q <= '0;
         addr_q   <= '0;
         wdata_q  <= '0;
         rdata_q  <= '0;
         error_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         write_q  <= write_d;
         funct3_q <= funct3_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         rdata_q  <= rdata_d;
         error_q  <= error_d;
      end
   end

   always_ff @(posedge clk) begin
      if (mem_we) memory[idx] <= store_word;
   end

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid, req_ready, req_write;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr, req_wdata;
   logic        rsp_valid, rsp_ready;
   logic [31:0] rsp_rdata;
   logic        rsp_error;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   dmem_responder #(.DEPTH_WORDS(32), .LATENCY(2)) dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_write  (req_write),
      .req_funct3 (req_funct3),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_rdata  (rsp_rdata),
      .rsp_error  (rsp_error)
   );

   typedef struct {
      string       name;
      logic        w;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_rdata;
      logic        exp_err;
   } vec_t;

   vec_t vecs [17];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   // Issue one request, measure cycles from acceptance to rsp_valid,
   // capture the response and complete the handshake.
   task automatic txn(input logic w, input logic [2:0] f3, input logic [31:0] a,
                      input logic [31:0] wd, output logic [31:0] rd,
                      output logic er, output int lat);
      @(negedge clk);
      req_valid = 1'b1; req_write = w; req_funct3 = f3; req_addr = a; req_wdata = wd;
      chk("req_ready_before_accept", {31'h0, req_ready}, 32'h1);
      @(posedge clk);
      #1 req_valid = 1'b0;
      lat = 1;
      @(negedge clk);
      while (!rsp_valid && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      rd = rsp_rdata;
      er = rsp_error;
      rsp_ready = 1'b1;
      @(posedge clk);
      #1 rsp_ready = 1'b0;
   endtask

   logic [31:0] rd, rd0;
   logic        er;
   int          lat;

   initial begin
      reset = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_funct3 = 3'b0;
      req_addr = '0; req_wdata = '0; rsp_ready = 1'b0;
      for (int i = 0; i < 32; i++) dut.memory[i] = 32'(i) * 32'h0101_0101;
      dut.memory[0] = 32'h0BAD_F00D;
      dut.memory[1] = 32'h8000_00F0;
      dut.memory[2] = 32'h1122_3344;

      vecs[0]  = '{"lw4",       1'b0, 3'b010, 32'd4,   32'h0,         32'h8000_00F0, 1'b0};
      vecs[1]  = '{"lb4",       1'b0, 3'b000, 32'd4,   32'h0,         32'hFFFF_FFF0, 1'b0};
      vecs[2]  = '{"lbu4",      1'b0, 3'b100, 32'd4,   32'h0,         32'h0000_00F0, 1'b0};
      vecs[3]  = '{"lh6",       1'b0, 3'b001, 32'd6,   32'h0,         32'hFFFF_8000, 1'b0};
      vecs[4]  = '{"lhu6",      1'b0, 3'b101, 32'd6,   32'h0,         32'h0000_8000, 1'b0};
      vecs[5]  = '{"sb9",       1'b1, 3'b000, 32'd9,   32'h0000_00AA, 32'h0,         1'b0};
      vecs[6]  = '{"lw8_a",     1'b0, 3'b010, 32'd8,   32'h0,         32'h1122_AA44, 1'b0};
      vecs[7]  = '{"sh10",      1'b1, 3'b001, 32'd10,  32'h0000_BEEF, 32'h0,         1'b0};
      vecs[8]  = '{"lw8_b",     1'b0, 3'b010, 32'd8,   32'h0,         32'hBEEF_AA44, 1'b0};
      vecs[9]  = '{"lw6_err",   1'b0, 3'b010, 32'd6,   32'h0,         32'h0,         1'b1};
      vecs[10] = '{"sh3_err",   1'b1, 3'b001, 32'd3,   32'h0000_5555, 32'h0,         1'b1};
      vecs[11] = '{"sw128_err", 1'b1, 3'b010, 32'd128, 32'hFFFF_FFFF, 32'h0,         1'b1};
      vecs[12] = '{"sbu_err",   1'b1, 3'b100, 32'd12,  32'hFFFF_FFFF, 32'h0,         1'b1};
      vecs[13] = '{"f3_011_err",1'b0, 3'b011, 32'd12,  32'h0,         32'h0,         1'b1};
      vecs[14] = '{"lw12_keep", 1'b0, 3'b010, 32'd12,  32'h0,         32'h0303_0303, 1'b0};
      vecs[15] = '{"lw124_top", 1'b0, 3'b010, 32'd124, 32'h0,         32'h1F1F_1F1F, 1'b0};
      vecs[16] = '{"lb7",       1'b0, 3'b000, 32'd7,   32'h0,         32'hFFFF_FF80, 1'b0};

      repeat (2) @(negedge clk);
      chk("rst_req_ready", {31'h0, req_ready}, 32'h1);
      chk("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
      chk("rst_rdata",     rsp_rdata,          32'h0);
      chk("rst_error",     {31'h0, rsp_error}, 32'h0);
      reset = 1'b1;

      for (int i = 0; i < 17; i++) begin
         txn(vecs[i].w, vecs[i].f3, vecs[i].addr, vecs[i].wdata, rd, er, lat);
         chk({vecs[i].name, "_rdata"}, rd, vecs[i].exp_rdata);
         chk({vecs[i].name, "_error"}, {31'h0, er}, {31'h0, vecs[i].exp_err});
         chk({vecs[i].name, "_latency"}, 32'(lat), 32'd2);
      end
      chk("mem1_after_errors", dut.memory[1], 32'h8000_00F0);

      // Backpressure: response must hold while rsp_ready is low.
      @(negedge clk);
      req_valid = 1'b1; req_write = 1'b0; req_funct3 = 3'b010; req_addr = 32'd4;
      @(posedge clk);
      #1 req_valid = 1'b0;
      repeat (2) @(negedge clk);
      chk("bp_valid_start", {31'h0, rsp_valid}, 32'h1);
      for (int c = 0; c < 5; c++) begin
         chk("bp_valid_hold", {31'h0, rsp_valid}, 32'h1);
         chk("bp_rdata_hold", rsp_rdata, 32'h8000_00F0);
         chk("bp_req_ready_low", {31'h0, req_ready}, 32'h0);
         @(negedge clk);
      end
      rsp_ready = 1'b1;
      @(posedge clk);
      #1 rsp_ready = 1'b0;
      chk("bp_req_ready_after", {31'h0, req_ready}, 32'h1);
      chk("bp_valid_after", {31'h0, rsp_valid}, 32'h0);

      // Reset during WAIT discards a pending store.
      @(negedge clk);
      req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'b010;
      req_addr = 32'd0; req_wdata = 32'hDEAD_BEEF;
      @(posedge clk);
      #1 req_valid = 1'b0;
      #2 reset = 1'b0;
      #1;
      chk("rw_rsp_valid", {31'h0, rsp_valid}, 32'h0);
      chk("rw_rdata", rsp_rdata, 32'h0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      chk("rw_req_ready_release", {31'h0, req_ready}, 32'h1);
      chk("rw_valid_release", {31'h0, rsp_valid}, 32'h0);
      txn(1'b0, 3'b010, 32'd0, 32'h0, rd0, er, lat);
      chk("rw_mem0_orig", rd0, 32'h0BAD_F00D);

      // Reset while a response is presented clears it.
      @(negedge clk);
      req_valid = 1'b1; req_write = 1'b0; req_funct3 = 3'b010; req_addr = 32'd4;
      @(posedge clk);
      #1 req_valid = 1'b0;
      repeat (2) @(negedge clk);
      chk("rr_valid_before", {31'h0, rsp_valid}, 32'h1);
      reset = 1'b0;
      #1;
      chk("rr_valid", {31'h0, rsp_valid}, 32'h0);
      chk("rr_rdata", rsp_rdata, 32'h0);
      chk("rr_req_ready", {31'h0, req_ready}, 32'h1);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
